// File: rtl/uart_baud_ctrl.sv
// Phase-accumulator baud tick generator: 16x oversample strobe plus 1x bit strobe.
// Optional macro UART_BAUD_RESYNC_EN enables bit-phase resync from the receiver.
module uart_baud_ctrl #(
    parameter logic [31:0] RESET_INC  = 32'd13743895,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_cfg_valid,
    input  logic [31:0] i_cfg_inc,
    output logic        o_cfg_ready,
    input  logic        i_rx_resync,
    output logic        o_os_tick,
    output logic        o_tx_tick
);

    localparam int unsigned          DIV_W   = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]     DIV_MAX = DIV_W'(OVERSAMPLE - 1);

    typedef enum logic [0:0] {
        StRun,
        StPend
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [31:0]       r_acc;
    logic [31:0]       r_inc;
    logic [31:0]       r_pend_inc;
    logic [DIV_W-1:0]  r_div;
    logic              r_os_tick;
    logic              r_tx_tick;

    logic [32:0]       w_sum;
    logic              w_carry;
    logic              w_div_max;
    logic              w_boundary;
    logic              w_transfer;
    logic              w_apply;
    logic              w_resync;

`ifdef UART_BAUD_RESYNC_EN
    assign w_resync = i_rx_resync;
`else
    logic w_unused_resync;
    assign w_resync        = 1'b0;
    assign w_unused_resync = i_rx_resync;
`endif

    assign w_sum      = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry    = w_sum[32];
    assign w_div_max  = (r_div == DIV_MAX);
    // A resync on the boundary carry suppresses the tick, so the apply waits too.
    assign w_boundary = i_enable && w_carry && w_div_max && !w_resync;
    assign w_transfer = i_cfg_valid && (r_state == StRun);
    assign w_apply    = (r_state == StPend) && (i_enable ? w_boundary : 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRun:   if (w_transfer) w_state_next = StPend;
            StPend:  if (w_apply)    w_state_next = StRun;
            default: w_state_next = StRun;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc      <= '0;
            r_div      <= '0;
            r_inc      <= RESET_INC;
            r_pend_inc <= '0;
            r_os_tick  <= 1'b0;
            r_tx_tick  <= 1'b0;
        end else begin
            if (w_resync) begin
                r_acc     <= '0;
                r_div     <= '0;
                r_os_tick <= 1'b0;
                r_tx_tick <= 1'b0;
            end else if (i_enable) begin
                r_acc     <= w_sum[31:0];
                r_os_tick <= w_carry;
                r_tx_tick <= w_carry && w_div_max;
                if (w_carry) begin
                    r_div <= r_div + DIV_W'(1);
                end
            end else begin
                r_os_tick <= 1'b0;
                r_tx_tick <= 1'b0;
            end
            if (w_transfer) begin
                r_pend_inc <= i_cfg_inc;
            end
            if (w_apply) begin
                r_inc <= r_pend_inc;
            end
        end
    end

    assign o_cfg_ready = (r_state == StRun);
    assign o_os_tick   = r_os_tick;
    assign o_tx_tick   = r_tx_tick;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed self-checking bench for uart_baud_ctrl; expected cycle numbers are hand-derived
// from the accumulator arithmetic. Tracks UART_BAUD_RESYNC_EN for the resync expectations.
module tb_uart_baud_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_inc = '0;
    logic        cfg_ready;
    logic        rx_resync = 1'b0;
    logic        os_tick;
    logic        tx_tick;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int os_cnt = 0;
    int tx_cnt = 0;
    int bad_cnt = 0;

    always #5 clk = ~clk;

    uart_baud_ctrl dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_cfg_valid (cfg_valid),
        .i_cfg_inc   (cfg_inc),
        .o_cfg_ready (cfg_ready),
        .i_rx_resync (rx_resync),
        .o_os_tick   (os_tick),
        .o_tx_tick   (tx_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; cyc counts edges since reset release, tick counters accumulate.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        os_cnt += int'(os_tick);
        tx_cnt += int'(tx_tick);
        if (tx_tick && !os_tick) bad_cnt++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic clr();
        os_cnt = 0;
        tx_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_os", {31'd0, os_tick}, 32'd0);
            chk("rst_tx", {31'd0, tx_tick}, 32'd0);
            chk("rst_rdy", {31'd0, cfg_ready}, 32'd1);
        end
        reset = 1'b0;
        cyc = 0;
        clr();
    endtask

    // Loads a new increment through the disabled-apply path; acc/div stay frozen.
    task automatic set_inc_disabled(input logic [31:0] v);
        enable    = 1'b0;
        cfg_valid = 1'b1;
        cfg_inc   = v;
        step();
        chk("dis_rdy_fall", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        step();
        chk("dis_rdy_back", {31'd0, cfg_ready}, 32'd1);
        chk("dis_no_os", {31'd0, os_tick}, 32'd0);
        enable = 1'b1;
    endtask

    initial begin
        int n;

        // Free run at the reset rate: carries at ceil(m * 312.5000...) additions.
        enable = 1'b1;
        do_reset();
        run_to(312);
        chk("first_os_early", os_cnt, 0);
        step();
        chk("first_os_313", {31'd0, os_tick}, 32'd1);
        run_to(5000);
        chk("first_tx_early", tx_cnt, 0);
        step();
        chk("first_tx_5001", {31'd0, tx_tick}, 32'd1);
        run_to(50000);
        chk("os_total_50k", os_cnt, 159);
        chk("tx_total_50k", tx_cnt, 9);

        // Rate change applied at the bit boundary; second offer held off while pending.
        do_reset();
        cfg_valid = 1'b1;
        cfg_inc   = 32'h8000_0000;
        step();
        chk("cfg_rdy_fall", {31'd0, cfg_ready}, 32'd0);
        cfg_inc = 32'h4000_0000;
        run_to(5000);
        chk("cfg_rdy_held", {31'd0, cfg_ready}, 32'd0);
        chk("cfg_no_tx_pre", tx_cnt, 0);
        step();
        chk("cfg_tx_5001", {31'd0, tx_tick}, 32'd1);
        chk("cfg_rdy_5001", {31'd0, cfg_ready}, 32'd1);
        step();
        chk("cfg2_accepted", {31'd0, cfg_ready}, 32'd0);
        chk("cfg_os_5002", {31'd0, os_tick}, 32'd0);
        cfg_valid = 1'b0;
        cfg_inc   = '0;
        step();
        chk("cfg_os_5003", {31'd0, os_tick}, 32'd1);
        clr();
        run_to(5032);
        chk("fast_os_cnt", os_cnt, 14);
        chk("fast_no_tx", tx_cnt, 0);
        step();
        chk("fast_tx_5033", {31'd0, tx_tick}, 32'd1);
        chk("cfg2_rdy_5033", {31'd0, cfg_ready}, 32'd1);
        clr();
        run_to(5036);
        chk("q_os_gap", os_cnt, 0);
        step();
        chk("q_os_5037", {31'd0, os_tick}, 32'd1);
        clr();
        run_to(5096);
        chk("q_no_tx", tx_cnt, 0);
        step();
        chk("q_tx_5097", {31'd0, tx_tick}, 32'd1);
        chk("cfg2_taken_once", {31'd0, cfg_ready}, 32'd1);

        // Resync on a carry cycle at inc = 2^31.
        do_reset();
        set_inc_disabled(32'h8000_0000);
        run_to(33);
        chk("half_os_cnt", os_cnt, 15);
        chk("half_no_tx", tx_cnt, 0);
        step();
        chk("half_tx_34", {31'd0, tx_tick}, 32'd1);
        run_to(39);
        rx_resync = 1'b1;
        step();
`ifdef UART_BAUD_RESYNC_EN
        chk("resync_os", {31'd0, os_tick}, 32'd0);
`else
        chk("resync_os", {31'd0, os_tick}, 32'd1);
`endif
        chk("resync_tx", {31'd0, tx_tick}, 32'd0);
        rx_resync = 1'b0;
        n = 0;
        while (!tx_tick && n < 200) begin
            step();
            n++;
        end
`ifdef UART_BAUD_RESYNC_EN
        chk("resync_next_tx", cyc, 72);
`else
        chk("resync_next_tx", cyc, 66);
`endif

        // Enable dropped mid-bit with a change pending: applies while frozen.
        do_reset();
        set_inc_disabled(32'h8000_0000);
        run_to(10);
        chk("frz_os_pre", os_cnt, 4);
        cfg_valid = 1'b1;
        cfg_inc   = 32'h4000_0000;
        step();
        chk("frz_rdy_fall", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        enable    = 1'b0;
        step();
        chk("frz_rdy_back", {31'd0, cfg_ready}, 32'd1);
        chk("frz_os_12", {31'd0, os_tick}, 32'd0);
        clr();
        run_to(21);
        chk("frz_no_os", os_cnt, 0);
        chk("frz_no_tx", tx_cnt, 0);
        enable = 1'b1;
        step();
        chk("frz_os_22", {31'd0, os_tick}, 32'd0);
        step();
        chk("frz_os_23", {31'd0, os_tick}, 32'd1);
        clr();
        run_to(66);
        chk("frz_no_tx_post", tx_cnt, 0);
        step();
        chk("frz_tx_67", {31'd0, tx_tick}, 32'd1);

        // Reset while a change is pending discards it.
        do_reset();
        cfg_valid = 1'b1;
        cfg_inc   = 32'h8000_0000;
        step();
        chk("rp_rdy_fall", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        run_to(10);
        do_reset();
        run_to(312);
        chk("rp_os_early", os_cnt, 0);
        step();
        chk("rp_os_313", {31'd0, os_tick}, 32'd1);
        run_to(5000);
        step();
        chk("rp_tx_5001", {31'd0, tx_tick}, 32'd1);
        clr();
        run_to(5010);
        chk("rp_no_apply", os_cnt, 0);

        chk("tx_with_os", bad_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Programmable baud-tick controller for the UART. A 32-bit phase accumulator produces a 16x oversample strobe for the receiver and a 1x bit strobe for the transmitter. Rate changes arrive over a valid/ready handshake and take effect only on a bit boundary, so a rate change never produces a truncated bit. The receiver can resynchronise the bit phase on start-bit detection. The block sits between the UART register interface and the tx/rx shifters, and replaces free-running fixed-rate tick generation.

## Interface
- RESET_INC, 32'd13743895, oversample increment after reset (2^32·16·9600/48 MHz, 153600 Hz oversample rate)
- OVERSAMPLE, 16, oversample ticks per bit; power of two, 4..16

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  1 = accumulate; 0 = freeze the accumulator and divider, and hold the ticks low
- cfg_valid  in  1  new increment offered
- cfg_inc  in  32  oversample increment, 2^32·f_os/f_clk; 0 is legal (no ticks)
- cfg_ready  out  1  1 = no change pending, cfg can be accepted
- rx_resync  in  1  single-cycle pulse from rx on start-bit edge
- os_tick  out  1  single-cycle oversample strobe
- tx_tick  out  1  single-cycle bit strobe

## Operation
- State: acc[31:0], div[log2(OVERSAMPLE)-1:0], inc[31:0], pend_inc[31:0], pend flag.
- Each enabled cycle: {carry, acc} <= acc + inc; os_tick <= carry.
- On carry: div <= div + 1, wrapping at OVERSAMPLE-1 → 0.
- tx_tick <= carry && div == OVERSAMPLE-1.
- Handshake: a transfer occurs when cfg_valid && cfg_ready.
  - On transfer: pend_inc <= cfg_inc, pend <= 1, cfg_ready <= 0.
  - If cfg_valid is high while cfg_ready is low, nothing is accepted; the requester holds cfg_inc.
- Apply rule, when pend = 1:
  - enable = 1: inc <= pend_inc on the cycle whose carry sets tx_tick (the bit boundary).
  - enable = 0: inc <= pend_inc on the next cycle.
  - On apply: pend <= 0, and cfg_ready returns to 1 the following cycle.
  - acc and div are not cleared on apply.
- States: RUN (pend = 0, cfg_ready = 1) → PEND on transfer → RUN on apply.
- rx_resync (see Configuration): acc <= 0, div <= 0, and os_tick/tx_tick are forced low that cycle. The next tx_tick lands exactly OVERSAMPLE os_ticks later.
- Simultaneous events:
  - rx_resync with a carry: resync wins, no ticks, and a pending apply is deferred to the next boundary.
  - A transfer can only occur in RUN, so a transfer never coincides with an apply.
- inc = 0: no ticks, so a pending change applies only when enable = 0 or via reset. This is documented, not an error.

## Timing
- Reset values: acc = 0, div = 0, inc = RESET_INC, pend = 0, os_tick = 0, tx_tick = 0, cfg_ready = 1. Reset overrides everything, including mid-pending changes, which are discarded.
- os_tick and tx_tick are registered: asserted one cycle after the carry-producing addition. tx_tick always coincides with an os_tick.
- os_tick period is floor or ceil of 2^32/inc cycles; average rate is exact to 2^-32.
- Handshake latency: cfg_ready falls the cycle after the transfer. The new rate governs the first accumulation after the boundary tx_tick.
- Deassertion of enable takes effect the same cycle: no tick is produced from a frozen cycle.

## Configuration
- UART_BAUD_RESYNC_EN:
  - Defined: rx_resync operates as described above.
  - Undefined: rx_resync is ignored (port retained, unused), and the phase runs freely from reset.

## Test plan
- Reset, RESET_INC, enable = 1 for 1,000,000 cycles → 3200 ±1 os_tick, 200 ±1 tx_tick; all outputs 0 during reset.
- cfg_inc = 32'h8000_0000 accepted → after the next tx_tick, os_tick every 2 cycles and tx_tick every 32 cycles; cfg_ready low from the cycle after the transfer until the cycle after that boundary.
- Second cfg_valid held while cfg_ready = 0 → not accepted until cfg_ready = 1; the value is then taken exactly once.
- inc = 32'h8000_0000, rx_resync pulsed on a carry cycle → no tick that cycle; next tx_tick exactly 32 cycles later. With the macro undefined, the tick pattern is unchanged.
- enable dropped for 10 cycles mid-bit → no ticks while low; phase resumes with the same acc/div; a pending cfg applies the cycle after enable falls.
- Reset asserted while pend = 1 → inc = RESET_INC, cfg_ready = 1, and the pending value is never applied.
